// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 constants, types and the key-expansion RCON lookup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] rkey_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Indexed by the round being generated (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] i_round);
        logic [7:0] v;
        case (i_round)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module : aes_sbox
// Brief  : Combinational 8-bit forward AES S-box (GF(2^8) inverse + affine).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; zero maps to zero as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv = ginv(i_in);
        o_out = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;
    end

endmodule

`default_nettype wire

// File: rtl/aes_key_schedule.sv
// ============================================================================
// Module : aes_key_schedule
// Brief  : Iterative AES-128 key expansion; streams 11 round keys out in
//          forward or reverse order over a valid/ready interface.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_key_schedule #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         dir,
    input  logic         clear,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    import aes_pkg::*;

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_key_schedule supports only NR = 10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] C_LAST = 4'(NR);

    state_t     r_state;
    rkey_t      r_key [0:NR];
    logic [3:0] r_cnt;
    logic       r_dir;
    logic       r_valid;
    rkey_t      r_data;
    logic [3:0] r_round;
    logic       r_busy;
    logic       r_done;

    rkey_t      w_prev;
    word_t      w_rot;
    word_t      w_sub;
    word_t      w_temp;
    word_t      w_n0, w_n1, w_n2, w_n3;
    rkey_t      w_next;
    logic [3:0] w_last;
    logic [3:0] w_idx_nxt;

    assign w_prev = r_key[r_cnt - 4'd1];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .i_in  (w_rot[8*g +: 8]),
                .o_out (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_temp = w_sub ^ {rcon(r_cnt), 24'h000000};
    assign w_n0   = w_prev[127:96] ^ w_temp;
    assign w_n1   = w_prev[95:64]  ^ w_n0;
    assign w_n2   = w_prev[63:32]  ^ w_n1;
    assign w_n3   = w_prev[31:0]   ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_last    = r_dir ? 4'd0 : C_LAST;
    assign w_idx_nxt = r_dir ? (r_round - 4'd1) : (r_round + 4'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_dir   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i <= NR; i++) r_key[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state <= IDLE;
                r_cnt   <= 4'd0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_key[0] <= key_in;
                            r_dir    <= dir;
                            r_cnt    <= 4'd1;
                            r_busy   <= 1'b1;
                            r_state  <= EXPAND;
                        end
                    end
                    EXPAND: begin
                        r_key[r_cnt] <= w_next;
                        if (r_cnt == C_LAST) begin
                            // Reverse order starts on the key computed this very cycle.
                            r_state <= STREAM;
                            r_valid <= 1'b1;
                            r_data  <= r_dir ? w_next : r_key[0];
                            r_round <= r_dir ? C_LAST : 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    STREAM: begin
                        if (r_valid && rk_ready) begin
                            if (r_round == w_last) begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_cnt   <= 4'd0;
                            end else begin
                                r_round <= w_idx_nxt;
                                r_data  <= r_key[w_idx_nxt];
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rk_valid = r_valid;
    assign rk_data  = r_data;
    assign rk_round = r_round;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
// ============================================================================
// Module : tb_aes_key_schedule
// Brief  : Scoreboard bench for aes_key_schedule using FIPS-197 vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         dir;
    logic         clear;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_schedule #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .dir      (dir),
        .clear    (clear),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] data;
        bit           chk;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] fips [0:10];
    logic [127:0] zk   [0:10];
    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_done   = 0;
    int cyc      = 0;
    int first_x  = 0;
    int last_x   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: sample the handshake at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst && !clear && rk_valid && rk_ready) begin
            n_xfer++;
            if (n_xfer == 1) first_x = cyc;
            last_x = cyc;
            if (sb.size() == 0) begin
                check("xfer_when_none_expected", 128'(rk_valid & rk_ready), 128'd0);
            end else begin
                e = sb.pop_front();
                check("rk_round", 128'(rk_round), 128'(e.rnd));
                if (e.chk) check("rk_data", rk_data, e.data);
            end
        end
        if (done) n_done++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push(input bit zero_tbl, input bit d, input int n);
        exp_t e;
        int   idx;
        for (int i = 0; i < n; i++) begin
            idx    = d ? 10 - i : i;
            e.rnd  = 4'(idx);
            e.data = zero_tbl ? zk[idx] : fips[idx];
            e.chk  = !zero_tbl || idx == 0 || idx == 1 || idx == 10;
            sb.push_back(e);
        end
    endtask

    task automatic launch(input logic [127:0] k, input bit d);
        start  = 1'b1;
        key_in = k;
        dir    = d;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rk_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input logic [127:0] k, input bit d, input bit zero_tbl,
                       input bit poke, input bit bp);
        int  lat;
        int  d0;
        int  kk;
        bit  held;
        n_xfer = 0;
        held   = 1'b0;
        push(zero_tbl, d, 11);
        launch(k, d);
        lat = 0;
        while (!rk_valid && lat < 30) begin
            check("busy_expand", 128'(busy), 128'd1);
            if (poke && lat == 4) begin
                start  = 1'b1;
                key_in = ~k;
                dir    = ~d;
            end
            tick();
            start = 1'b0;
            dir   = d;
            lat++;
        end
        check("latency", 128'(lat), 128'd10);
        check("busy_stream", 128'(busy), 128'd1);
        d0 = n_done;
        kk = 0;
        while (n_done == d0 && kk < 80) begin
            if (bp && !held && rk_valid && rk_round == 4'd3) begin
                rk_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    check("bp_valid", 128'(rk_valid), 128'd1);
                    check("bp_round", 128'(rk_round), 128'd3);
                    check("bp_data", rk_data, 128'h3d80477d4716fe3e1e237e446d7a883b);
                end
                rk_ready = 1'b1;
                held     = 1'b1;
            end
            tick();
            kk++;
        end
        check("done_pulses", 128'(n_done - d0), 128'd1);
        check("xfer_count", 128'(n_xfer), 128'd11);
        if (!bp) check("xfer_back_to_back", 128'(last_x - first_x), 128'd10);
        check("sb_empty", 128'(sb.size()), 128'd0);
        check("idle_valid", 128'(rk_valid), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        tick();
        check("done_one_cycle", 128'(n_done - d0), 128'd1);
    endtask

    initial begin
        int  lat;
        int  d0;
        bit  any_valid;

        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) zk[i] = '0;
        zk[1]  = 128'h62636363626363636263636362636363;
        zk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst      = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        dir      = 1'b0;
        clear    = 1'b0;
        rk_ready = 1'b1;
        #12;
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_data", rk_data, 128'd0);
        check("rst_round", 128'(rk_round), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        rst = 1'b1;
        tick();

        run(fips[0], 1'b0, 1'b0, 1'b0, 1'b0);
        run(fips[0], 1'b1, 1'b0, 1'b1, 1'b0);
        run(fips[0], 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort during expansion.
        n_xfer = 0;
        d0     = n_done;
        launch(fips[0], 1'b0);
        for (int i = 0; i < 4; i++) tick();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clr_exp_valid", 128'(rk_valid), 128'd0);
        check("clr_exp_busy", 128'(busy), 128'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            any_valid |= rk_valid;
            tick();
        end
        check("clr_exp_no_valid", 128'(any_valid), 128'd0);
        check("clr_exp_no_done", 128'(n_done - d0), 128'd0);

        // Abort during streaming, after rounds 0..2 have transferred.
        n_xfer = 0;
        d0     = n_done;
        push(1'b0, 1'b0, 3);
        launch(fips[0], 1'b0);
        wait_valid(lat);
        check("clr_str_latency", 128'(lat), 128'd10);
        for (int i = 0; i < 3; i++) tick();
        check("clr_str_round3", 128'(rk_round), 128'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_str_valid", 128'(rk_valid), 128'd0);
        check("clr_str_busy", 128'(busy), 128'd0);
        check("clr_str_done", 128'(done), 128'd0);
        for (int i = 0; i < 5; i++) tick();
        check("clr_str_no_done", 128'(n_done - d0), 128'd0);
        check("clr_str_sb_empty", 128'(sb.size()), 128'd0);

        run(fips[0], 1'b1, 1'b0, 1'b0, 1'b0);
        run(128'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stalled stream.
        rk_ready = 1'b0;
        launch(fips[0], 1'b1);
        wait_valid(lat);
        tick();
        tick();
        check("pre_rst_valid", 128'(rk_valid), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 128'(rk_valid), 128'd0);
        check("arst_data", rk_data, 128'd0);
        check("arst_round", 128'(rk_round), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        tick();
        rst      = 1'b1;
        rk_ready = 1'b1;
        tick();

        run(fips[0], 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
